excess3_seq_decoder: RTL and testbench

//  Sequencing controller for the excess-3 to binary conversion datapath.

---
 rtl/excess3_seq_decoder.sv | 133 +++++++++++++
 tb/tb_excess3_seq_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/excess3_seq_decoder.sv
// excess3_seq_decoder: serial excess-3 to binary conversion controller.
// Accepts NUM_DIGITS excess-3 digits (MSD first), strips the +3 bias,
// accumulates acc*10+digit and returns one result or an error through a
// valid/ready handshake. All outputs are registered.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin a conversion (IDLE only)
//   abort                  drop the conversion in progress (COLLECT only)
//   in_digit, in_valid     excess-3 digit input
//   in_ready               high while digits are being collected
//   bin_out, err           result value / invalid-digit flag
//   out_valid, out_ready   result handshake
//   busy                   high in any state other than IDLE
//   digit_idx              number of valid digits accepted so far
module excess3_seq_decoder #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned BIN_W      = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [3:0]                         in_digit,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [BIN_W-1:0]                   bin_out,
  output logic                               err,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESULT  = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [BIN_W-1:0]   acc_q, acc_n;
  logic [IDX_W-1:0]   idx_n;
  logic [BIN_W-1:0]   bin_n;
  logic               err_n;

  logic               digit_ok;
  logic [3:0]         digit_val;
  logic [BIN_W-1:0]   acc_mac;
  logic [IDX_W-1:0]   idx_inc;

  // Legal excess-3 codes are 3..12; multiply-by-10 is done as two shifts.
  assign digit_ok  = (in_digit >= 4'd3) && (in_digit <= 4'd12);
  assign digit_val = in_digit - 4'd3;
  assign acc_mac   = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit_val);
  assign idx_inc   = digit_idx + IDX_W'(1);

  // Next-state and next-register values.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    idx_n   = digit_idx;
    bin_n   = bin_out;
    err_n   = err;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_COLLECT;
          acc_n   = '0;
          idx_n   = '0;
          err_n   = 1'b0;
        end
      end
      S_COLLECT: begin
        // abort wins over a digit offered in the same cycle
        if (abort) begin
          state_n = S_IDLE;
          acc_n   = '0;
          idx_n   = '0;
        end else if (in_valid) begin
          if (digit_ok) begin
            acc_n = acc_mac;
            idx_n = idx_inc;
            if (idx_inc == IDX_W'(NUM_DIGITS)) begin
              state_n = S_RESULT;
              bin_n   = acc_mac;
            end
          end else begin
            state_n = S_ERROR;
            bin_n   = '0;
            err_n   = 1'b1;
          end
        end
      end
      S_RESULT, S_ERROR: begin
        if (out_ready) begin
          state_n = S_IDLE;
          acc_n   = '0;
          idx_n   = '0;
          bin_n   = '0;
          err_n   = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; control outputs follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      digit_idx <= '0;
      bin_out   <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      digit_idx <= idx_n;
      bin_out   <= bin_n;
      err       <= err_n;
      in_ready  <= (state_n == S_COLLECT);
      out_valid <= (state_n == S_RESULT) || (state_n == S_ERROR);
      busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_excess3_seq_decoder.sv
// Testbench for excess3_seq_decoder: directed scenarios with literal
// expectations plus a randomized run, all cross-checked every cycle against
// a behavioural conversion model.
module tb_excess3_seq_decoder;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned BIN_W      = 10;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       in_digit = 4'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BIN_W-1:0] bin_out;
  logic             err;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic [IDX_W-1:0] digit_idx;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  excess3_seq_decoder #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_digit(in_digit), .in_valid(in_valid), .in_ready(in_ready),
    .bin_out(bin_out), .err(err), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = idle, 1 = taking digits, 2 = answer presented.
  int m_phase  = 0;
  int m_digits = 0;
  int m_val    = 0;
  bit m_err    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  = 0;
      m_digits = 0;
      m_val    = 0;
      m_err    = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_phase = 1; m_digits = 0; m_val = 0; m_err = 1'b0;
           end
        1: if (abort) begin
             m_phase = 0;
           end else if (in_valid) begin
             if (int'(in_digit) >= 3 && int'(in_digit) <= 12) begin
               m_val = m_val * 10 + (int'(in_digit) - 3);
               m_digits++;
               if (m_digits == NUM_DIGITS) m_phase = 2;
             end else begin
               m_err   = 1'b1;
               m_phase = 2;
             end
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  32'(in_ready),  32'(m_phase == 1));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      check("busy",      32'(busy),      32'(m_phase != 0));
      check("err",       32'(err),       32'(m_phase == 2 && m_err));
      if (m_phase != 0) check("digit_idx", 32'(digit_idx), 32'(m_digits));
      if (m_phase == 2) check("bin_out", 32'(bin_out), m_err ? 32'd0 : 32'(m_val % 1024));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d, input int gap);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      in_digit = 4'($urandom_range(0, 15));
      cyc();
    end
    in_valid = 1'b1; in_digit = d; cyc();
    in_valid = 1'b0;
  endtask

  task automatic finish_out();
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
  endtask

  task automatic conv3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input int maxgap);
    do_start();
    send_digit(a, $urandom_range(0, maxgap));
    send_digit(b, $urandom_range(0, maxgap));
    send_digit(c, $urandom_range(0, maxgap));
  endtask

  initial begin
    // Reset asserted mid-phase, before any active edge has mattered.
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready",  32'(in_ready),  32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst err",       32'(err),       32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst bin_out",   32'(bin_out),   32'd0);
    check("rst digit_idx", 32'(digit_idx), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    cyc();

    // 0100,0101,0110 back to back -> 123
    conv3(4'b0100, 4'b0101, 4'b0110, 0);
    check("s2 out_valid", 32'(out_valid), 32'd1);
    check("s2 bin_out",   32'(bin_out),   32'd123);
    check("s2 err",       32'(err),       32'd0);
    check("s2 digit_idx", 32'(digit_idx), 32'd3);
    // backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("s5 hold bin_out",   32'(bin_out),   32'd123);
      check("s5 hold out_valid", 32'(out_valid), 32'd1);
    end
    finish_out();
    check("s5 busy after hs",  32'(busy),      32'd0);
    check("s5 ov after hs",    32'(out_valid), 32'd0);

    // boundaries
    conv3(4'b0011, 4'b0011, 4'b0011, 0);
    check("s3 zero", 32'(bin_out), 32'd0);
    finish_out();
    conv3(4'b1100, 4'b1100, 4'b1100, 0);
    check("s3 999", 32'(bin_out), 32'h3E7);
    finish_out();

    // invalid digit -> error, third digit refused
    do_start();
    send_digit(4'b0111, 0);
    send_digit(4'b0010, 0);
    check("s4 out_valid", 32'(out_valid), 32'd1);
    check("s4 err",       32'(err),       32'd1);
    check("s4 bin_out",   32'(bin_out),   32'd0);
    check("s4 in_ready",  32'(in_ready),  32'd0);
    send_digit(4'b0101, 0);
    check("s4 still err", 32'(err), 32'd1);
    finish_out();

    // abort after one digit, with a digit offered the same cycle
    do_start();
    send_digit(4'b0101, 0);
    abort = 1'b1; in_valid = 1'b1; in_digit = 4'b0110; cyc();
    abort = 1'b0; in_valid = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    cyc();
    check("abort no ov", 32'(out_valid), 32'd0);

    // start in the handshake cycle is ignored
    conv3(4'b0100, 4'b0100, 4'b0100, 1);
    check("s6 111", 32'(bin_out), 32'd111);
    start = 1'b1; out_ready = 1'b1; cyc();
    start = 1'b0; out_ready = 1'b0;
    check("start in result busy", 32'(busy), 32'd0);
    cyc();
    check("start in result stays idle", 32'(busy), 32'd0);

    // reset pulse after two digits, then a fresh run
    do_start();
    send_digit(4'b1000, 0);
    send_digit(4'b1001, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst busy",      32'(busy),      32'd0);
    check("mid rst digit_idx", 32'(digit_idx), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    conv3(4'b1010, 4'b1011, 4'b1100, 0);
    check("after rst 789", 32'(bin_out), 32'd789);
    finish_out();

    // gaps of 0..3 idle cycles between digits
    for (int r = 0; r < 4; r++) begin
      conv3(4'b0100, 4'b0101, 4'b0110, 3);
      check("gap 123", 32'(bin_out), 32'd123);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end

    // randomized traffic; out_ready pre-asserted at times
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 24) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) in_digit = 4'($urandom_range(0, 15));
      else                           in_digit = 4'(3 + $urandom_range(0, 9));
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
